// File: rtl/sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding, the
// default halt word and the opcode constants used to build program images.
package sequencer_pkg;

    localparam int unsigned INSTR_W = 16;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HALTED = 3'd4
    } seq_state_e;

    localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 16'hFFFF;

    // Datapath opcodes (top nibble of the instruction word).
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h5;

    // Pack four nibble fields into one instruction word.
    function automatic logic [INSTR_W-1:0] encode_instr(
        input logic [3:0] op,
        input logic [3:0] f2,
        input logic [3:0] f1,
        input logic [3:0] f0
    );
        return {op, f2, f1, f0};
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Brings a raw push-button into the clk domain and emits a one-cycle pulse on
// each rising edge. A button level captured at edge k produces pulse=1 in the
// cycle after edge k+2, so a consumer sampling it acts on edge k+3.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   btn_async  raw asynchronous button level
//   pulse      registered one-cycle rising-edge pulse
module btn_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn_async,
    output logic pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic pulse_q, pulse_d;

    // Two-flop synchronizer followed by an edge detector on the clean level.
    always_comb begin
        sync1_d = btn_async;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        pulse_d = sync2_q & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer for the FSM datapath. Holds a loadable program memory and
// issues one instruction at a time, waiting for cpu_done before advancing.
// Free-run (run_mode=1) or single-step via a synchronized push-button.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   step_btn      raw push-button, one issue per press in step mode
//   run_mode      1 = free-run, 0 = single-step (looked at in IDLE)
//   restart       pulse: pc back to 0, re-enter INIT, program kept
//   prog_we/addr/data  program write port, accepted in IDLE or HALTED
//   cpu_done      datapath retired the current instruction
//   cpu_rst       reset to the datapath
//   instr_out     issued instruction, held until the next issue
//   imm_out       zero-extended pc of the issued instruction
//   instr_valid   one-cycle pulse while in ISSUE
//   pc            address of the next instruction to issue
//   halted        high while in HALTED
module instr_sequencer
    import sequencer_pkg::*;
#(
    parameter int unsigned    DEPTH      = 32,
    parameter int unsigned    RST_CYCLES = 4,
    parameter logic [15:0]    HALT_WORD  = HALT_WORD_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     step_btn,
    input  logic                     run_mode,
    input  logic                     restart,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [15:0]              prog_data,
    input  logic                     cpu_done,
    output logic                     cpu_rst,
    output logic [15:0]              instr_out,
    output logic [15:0]              imm_out,
    output logic                     instr_valid,
    output logic [$clog2(DEPTH)-1:0] pc,
    output logic                     halted
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(RST_CYCLES + 1);

    seq_state_e     state_q, state_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [15:0]    instr_q, instr_d;
    logic [15:0]    imm_q, imm_d;
    logic           valid_q, valid_d;
    logic           cpu_rst_q, cpu_rst_d;
    logic           halted_q, halted_d;

    logic [15:0]    mem_q [DEPTH];
    logic [15:0]    mem_rd;
    logic           step_pulse;

    btn_edge_sync u_btn (
        .clk       (clk),
        .rst       (rst),
        .btn_async (step_btn),
        .pulse     (step_pulse)
    );

    // Combinational read at pc; a same-cycle write is seen one cycle later.
    assign mem_rd = mem_q[pc_q];

    // Program memory write port, only while the sequencer is parked.
    always_ff @(posedge clk) begin
        if (prog_we && (state_q == ST_IDLE || state_q == ST_HALTED)) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    // Next-state and registered-output logic; outputs are set on the
    // transition into a state so they line up with that state's cycle.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        instr_d   = instr_q;
        imm_d     = imm_q;
        valid_d   = 1'b0;
        cpu_rst_d = cpu_rst_q;
        halted_d  = halted_q;

        case (state_q)
            ST_INIT: begin
                if (cnt_q == CW'(RST_CYCLES - 1)) begin
                    state_d   = ST_IDLE;
                    cpu_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_IDLE: begin
                if (mem_rd == HALT_WORD) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end else if (run_mode || step_pulse) begin
                    state_d = ST_ISSUE;
                    instr_d = mem_rd;
                    imm_d   = 16'(pc_q);
                    valid_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cpu_done) begin
                    // Last word retires into HALTED rather than wrapping.
                    if (pc_q == AW'(DEPTH - 1)) begin
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d   = ST_INIT;
                cnt_d     = '0;
                cpu_rst_d = 1'b1;
            end
        endcase

        // restart overrides every state, abandoning any outstanding instruction.
        if (restart) begin
            state_d   = ST_INIT;
            pc_d      = '0;
            cnt_d     = '0;
            cpu_rst_d = 1'b1;
            halted_d  = 1'b0;
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            pc_q      <= '0;
            cnt_q     <= '0;
            instr_q   <= '0;
            imm_q     <= '0;
            valid_q   <= 1'b0;
            cpu_rst_q <= 1'b1;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            instr_q   <= instr_d;
            imm_q     <= imm_d;
            valid_q   <= valid_d;
            cpu_rst_q <= cpu_rst_d;
            halted_q  <= halted_d;
        end
    end

    assign cpu_rst     = cpu_rst_q;
    assign instr_out   = instr_q;
    assign imm_out     = imm_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed timing checks plus randomized program
// images checked against an issue-list model computed from the program.
module tb_instr_sequencer;
    import sequencer_pkg::*;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;
    localparam logic [15:0] HALT  = 16'hFFFF;

    logic          clk = 1'b0;
    logic          rst, step_btn, run_mode, restart, prog_we, cpu_done;
    logic [AW-1:0] prog_addr;
    logic [15:0]   prog_data;
    logic          cpu_rst, instr_valid, halted;
    logic [15:0]   instr_out, imm_out;
    logic [AW-1:0] pc;

    logic [15:0]   model_mem [DEPTH];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc_cnt = 0;

    instr_sequencer #(
        .DEPTH      (DEPTH),
        .RST_CYCLES (4),
        .HALT_WORD  (HALT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .step_btn    (step_btn),
        .run_mode    (run_mode),
        .restart     (restart),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .cpu_done    (cpu_done),
        .cpu_rst     (cpu_rst),
        .instr_out   (instr_out),
        .imm_out     (imm_out),
        .instr_valid (instr_valid),
        .pc          (pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write one word through the program port and mirror it in the model.
    task automatic load_word(input int addr, input logic [15:0] data);
        prog_we   = 1'b1;
        prog_addr = AW'(addr);
        prog_data = data;
        @(negedge clk);
        prog_we   = 1'b0;
        model_mem[addr] = data;
    endtask

    task automatic start_run(input logic rm);
        run_mode = rm;
        restart  = 1'b1;
        @(negedge clk);
        restart  = 1'b0;
    endtask

    // Run from pc 0 until HALTED, answering each issue with cpu_done, and
    // compare the issue stream with the list derived from model_mem.
    task automatic run_check(input string tag, input int fixed_dly);
        int exp_q[$];
        int final_pc;
        int got_n  = 0;
        int last_v = -1;
        int t0;
        int dly;
        int i = 0;
        forever begin
            if (model_mem[i] == HALT) begin final_pc = i; break; end
            exp_q.push_back(i);
            if (i == DEPTH - 1) begin final_pc = i; break; end
            i++;
        end
        t0 = cyc_cnt;
        while (!halted && (cyc_cnt - t0) < 2000) begin
            @(negedge clk);
            if (instr_valid) begin
                if (got_n < exp_q.size()) begin
                    chk({tag, "_instr"}, 32'(instr_out), 32'(model_mem[exp_q[got_n]]));
                    chk({tag, "_imm"}, 32'(imm_out), 32'(exp_q[got_n]));
                end
                if (fixed_dly == 0 && last_v >= 0)
                    chk({tag, "_gap"}, 32'(cyc_cnt - last_v), 32'd3);
                last_v = cyc_cnt;
                got_n++;
                dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
                repeat (1 + dly) @(negedge clk);
                cpu_done = 1'b1;
                @(negedge clk);
                cpu_done = 1'b0;
            end
        end
        chk({tag, "_halted"}, 32'(halted), 32'd1);
        chk({tag, "_count"}, 32'(got_n), 32'(exp_q.size()));
        chk({tag, "_pc"}, 32'(pc), 32'(final_pc));
    endtask

    // Hold the button for 10 cycles, watch 20 cycles, report issues seen.
    task automatic press(output int n_valid, output int v_cyc, output int k_cyc);
        n_valid  = 0;
        v_cyc    = -1;
        step_btn = 1'b1;
        k_cyc    = cyc_cnt + 1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (j == 9) step_btn = 1'b0;
            if (instr_valid) begin
                n_valid++;
                if (v_cyc < 0) v_cyc = cyc_cnt;
            end
        end
    endtask

    initial begin
        int nv, vc, kc, seen;
        logic [15:0] w;

        rst = 1'b1; step_btn = 1'b0; run_mode = 1'b0; restart = 1'b0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0; cpu_done = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0000;

        // Reset: cpu_rst held 4 cycles after rst falls.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_instr", 32'(instr_out), 32'd0);
        chk("rst_imm", 32'(imm_out), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("rst_cpu_rst_hi", 32'(cpu_rst), 32'd1);
            @(negedge clk);
        end
        chk("rst_cpu_rst_lo", 32'(cpu_rst), 32'd0);

        // Free-run over a three-word program, back-to-back done.
        load_word(0, encode_instr(OP_ADDI, 4'h1, 4'h0, 4'h0));
        load_word(1, encode_instr(OP_ADD, 4'h2, 4'h5, 4'h1));
        load_word(2, HALT);
        start_run(1'b1);
        run_check("run3", 0);

        // Single-step mode.
        start_run(1'b0);
        repeat (5) @(negedge clk);
        chk("step_cpu_rst", 32'(cpu_rst), 32'd0);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (instr_valid) seen++;
        end
        chk("step_nobtn", 32'(seen), 32'd0);
        press(nv, vc, kc);
        chk("step_one", 32'(nv), 32'd1);
        chk("step_lat", 32'(vc - kc), 32'd3);
        chk("step_instr0", 32'(instr_out), 32'h5100);
        chk("step_imm0", 32'(imm_out), 32'd0);
        // Still in WAIT: a second press and a program write must both be dropped.
        step_btn = 1'b1;
        seen = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (j == 9) step_btn = 1'b0;
            if (j == 12) begin prog_we = 1'b1; prog_addr = AW'(1); prog_data = 16'hABCD; end
            if (j == 13) prog_we = 1'b0;
            if (instr_valid) seen++;
        end
        chk("step_wait_press", 32'(seen), 32'd0);
        cpu_done = 1'b1;
        @(negedge clk);
        cpu_done = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (instr_valid) seen++;
        end
        chk("step_no_queue", 32'(seen), 32'd0);
        chk("step_pc1", 32'(pc), 32'd1);
        press(nv, vc, kc);
        chk("step_two", 32'(nv), 32'd1);
        chk("we_ignored", 32'(instr_out), 32'h0251);
        chk("step_imm1", 32'(imm_out), 32'd1);
        cpu_done = 1'b1;
        @(negedge clk);
        cpu_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("step_halted", 32'(halted), 32'd1);
        chk("step_pc2", 32'(pc), 32'd2);

        // Full memory with no halt word: stops at the last address.
        for (int i = 0; i < DEPTH; i++) load_word(i, 16'($urandom_range(0, 16'hFFFE)));
        start_run(1'b1);
        run_check("full", -1);

        // restart while an instruction is outstanding.
        load_word(6, HALT);
        start_run(1'b1);
        seen = 0;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            @(negedge clk);
            if (instr_valid) seen = 1;
        end
        chk("rs_first_issue", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        start_run(1'b0);
        chk("rs_pc", 32'(pc), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("rs_cpu_rst_hi", 32'(cpu_rst), 32'd1);
            cpu_done = (i == 1);
            @(negedge clk);
        end
        cpu_done = 1'b0;
        chk("rs_cpu_rst_lo", 32'(cpu_rst), 32'd0);
        repeat (5) @(negedge clk);
        chk("rs_late_done", 32'(pc), 32'd0);
        run_mode = 1'b1;
        run_check("rs_rerun", -1);

        // Randomized program images with scattered halt words.
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < DEPTH; i++) begin
                w = ($urandom_range(0, 5) == 0) ? HALT : 16'($urandom_range(0, 16'hFFFE));
                load_word(i, w);
            end
            start_run(1'b1);
            run_check($sformatf("rand%0d", it), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
